// File: rtl/branch_pkg.sv
// Shared constants, FSM encoding and counter helper for the branch resolve unit.
package branch_pkg;

    // Conditional-branch funct3 encodings
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Every history counter starts weakly not-taken
    localparam logic [1:0] BHT_RST = 2'b01;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    // Saturating 2-bit counter step: up on taken (cap 3), down on not-taken (floor 0)
    function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken && c != 2'b11)
            r = c + 2'd1;
        else if (!taken && c != 2'b00)
            r = c - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters, async read, single update port.
module branch_bht
    import branch_pkg::*;
#(
    parameter  int BHT_ENTRIES = 16,
    localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] cnt [BHT_ENTRIES];

    // Read sees the registered table, so a same-index write this cycle is not visible yet
    assign rd_cnt = cnt[rd_idx];

    // Counter array with reset to weakly not-taken and saturating training
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                cnt[i] <= BHT_RST;
        end else if (wr_en) begin
            cnt[wr_idx] <= sat_upd(cnt[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps in EX, checks the fetch prediction, issues redirect/flush, trains the BHT.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter  int BHT_ENTRIES  = 16,
    parameter  int FLUSH_CYCLES = 1,
    parameter  int CNT_W        = 32,
    localparam int IDX_W        = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             BrUn,
    input  logic             BrEq,
    input  logic             BrLT,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             illegal_br,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES);

    br_state_e   state_q, state_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic        resolve, res_br, f3_bad, br_taken, actual, mispredict;
    logic [31:0] next_pc;
    logic [1:0]  rd_cnt;
    logic        unused_pc_bits;

    // Unsigned compare for BLTU/BGEU
    assign BrUn = (ex_funct3[2:1] == 2'b11);

    assign resolve = ex_valid & ~ex_stall & (state_q == IDLE) & (ex_is_branch | ex_is_jump);
    // A jump wins over the branch flag, so only non-jumps count as branches
    assign res_br  = resolve & ~ex_is_jump;

    // Branch direction from comparator flags; 010/011 are illegal and never taken
    always_comb begin
        br_taken = 1'b0;
        f3_bad   = 1'b0;
        case (ex_funct3)
            BEQ:        br_taken = BrEq;
            BNE:        br_taken = ~BrEq;
            BLT, BLTU:  br_taken = BrLT;
            BGE, BGEU:  br_taken = ~BrLT;
            default:    f3_bad   = 1'b1;
        endcase
    end

    assign actual     = ex_is_jump | br_taken;
    assign mispredict = resolve & ((actual != ex_pred_taken) |
                                   (actual & ex_pred_taken & (ex_target != ex_pred_target)));
    assign next_pc    = actual ? ex_target : ex_pc + 32'd4;

    // FSM state and flush countdown; countdown runs regardless of ex_stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state: enter FLUSH on mispredict, stay for FLUSH_CYCLES cycles
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FC_LOAD;
                end
            end
            FLUSH: begin
                fcnt_d = fcnt_q - 2'd1;
                if (fcnt_q <= 2'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Direct state decode so reset drops flush asynchronously
    assign flush = (state_q == FLUSH);

    // Registered redirect, illegal pulse and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            illegal_br     <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict)
                redirect_pc <= next_pc;
            illegal_br     <= res_br & f3_bad;
            branch_cnt     <= branch_cnt + CNT_W'(res_br);
            mispredict_cnt <= mispredict_cnt + CNT_W'(mispredict);
        end
    end

    branch_bht #(.BHT_ENTRIES(BHT_ENTRIES)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .wr_en    (res_br & ~f3_bad),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (br_taken)
    );

    assign if_pred_taken  = rd_cnt[1];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], rd_cnt[0]};

endmodule
